ula_arbitro_2p: RTL and testbench



---
 rtl/ula_arbitro_2p.sv | 162 ++++++++++++++++
 tb/tb_ula_arbitro_2p.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbitro_2p.sv
// Round-robin front-end sharing one ula_8bits between two requesters; response 2 cycles after acceptance, held until Resp_Ready.
// Optional feature: define ULA_ARB_CHECA_DIV0_EN to flag division/remainder by zero (Resultado=16'hFFFF, Erro=1).

module ula_8bits (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  sel_op,
  output logic [15:0] resultado,
  output logic        ilegal
);

  always_comb begin
    resultado = 16'h0000;
    ilegal    = 1'b0;
    case (sel_op)
      4'b0000: resultado = {8'h00, a + b};
      4'b0001: resultado = {8'h00, a - b};
      4'b0010: resultado = {8'h00, a} * {8'h00, b};
      // Division by zero yields zero here; the front-end may override it.
      4'b0011: if (b != 8'h00) resultado = {8'h00, a / b};
      4'b0100: if (b != 8'h00) resultado = {8'h00, a % b};
      4'b0110: resultado = {8'h00, a & b};
      4'b0111: resultado = {8'h00, a | b};
      4'b1000: resultado = {8'h00, ~(a & b)};
      4'b1001: resultado = {8'h00, ~(a | b)};
      4'b1010: resultado = {8'h00, a ^ b};
      4'b1011: resultado = {8'h00, ~a};
      default: ilegal = 1'b1;
    endcase
  end

endmodule

module ula_arbitro_2p (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_Valid_0,
  input  logic        Req_Valid_1,
  output logic        Req_Ready_0,
  output logic        Req_Ready_1,
  input  logic [7:0]  A_0,
  input  logic [7:0]  B_0,
  input  logic [7:0]  A_1,
  input  logic [7:0]  B_1,
  input  logic [3:0]  Sel_Op_0,
  input  logic [3:0]  Sel_Op_1,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic        Resp_Id,
  output logic [15:0] Resultado,
  output logic        Maior,
  output logic        Menor,
  output logic        Igual,
  output logic        Erro
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

  estado_t     estado;
  logic        ptr;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [3:0]  op_q;
  logic        id_q;
  logic        resp_valid_q;
  logic [15:0] resultado_q;
  logic        maior_q;
  logic        menor_q;
  logic        igual_q;
  logic        erro_q;

  logic        grant_id;
  logic        algum;
  logic [15:0] alu_res;
  logic        alu_ilegal;
  logic        div_zero;
  logic [15:0] res_final;
  logic        erro_final;

  // Pointer only matters under contention; a lone requester always wins.
  assign algum    = Req_Valid_0 | Req_Valid_1;
  assign grant_id = (Req_Valid_0 && Req_Valid_1) ? ptr : Req_Valid_1;

  assign Req_Ready_0 = !rst && (estado == OCIOSO) && Req_Valid_0 && (grant_id == 1'b0);
  assign Req_Ready_1 = !rst && (estado == OCIOSO) && Req_Valid_1 && (grant_id == 1'b1);

  ula_8bits u_ula (
    .a         (a_q),
    .b         (b_q),
    .sel_op    (op_q),
    .resultado (alu_res),
    .ilegal    (alu_ilegal)
  );

`ifdef ULA_ARB_CHECA_DIV0_EN
  assign div_zero = ((op_q == 4'b0011) || (op_q == 4'b0100)) && (b_q == 8'h00);
`else
  assign div_zero = 1'b0;
`endif

  assign res_final  = alu_ilegal ? 16'h0000 : (div_zero ? 16'hFFFF : alu_res);
  assign erro_final = alu_ilegal | div_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= OCIOSO;
      ptr          <= 1'b0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      op_q         <= 4'h0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resultado_q  <= 16'h0000;
      maior_q      <= 1'b0;
      menor_q      <= 1'b0;
      igual_q      <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          resp_valid_q <= 1'b0;
          if (algum) begin
            a_q    <= grant_id ? A_1 : A_0;
            b_q    <= grant_id ? B_1 : B_0;
            op_q   <= grant_id ? Sel_Op_1 : Sel_Op_0;
            id_q   <= grant_id;
            ptr    <= ~grant_id;
            estado <= EXECUTA;
          end
        end
        EXECUTA: begin
          resultado_q  <= res_final;
          erro_q       <= erro_final;
          maior_q      <= (a_q > b_q);
          menor_q      <= (a_q < b_q);
          igual_q      <= (a_q == b_q);
          resp_valid_q <= 1'b1;
          estado       <= RESPONDE;
        end
        RESPONDE: begin
          if (Resp_Ready) begin
            resp_valid_q <= 1'b0;
            estado       <= OCIOSO;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          estado       <= OCIOSO;
        end
      endcase
    end
  end

  assign Resp_Valid = resp_valid_q;
  assign Resp_Id    = id_q;
  assign Resultado  = resultado_q;
  assign Maior      = maior_q;
  assign Menor      = menor_q;
  assign Igual      = igual_q;
  assign Erro       = erro_q;

endmodule

// File: tb/tb_ula_arbitro_2p.sv
// Randomized scoreboard bench for ula_arbitro_2p with an arithmetic reference model.
module tb_ula_arbitro_2p;

  logic        clk;
  logic        rst;
  logic        Req_Valid_0, Req_Valid_1;
  logic        Req_Ready_0, Req_Ready_1;
  logic [7:0]  A_0, B_0, A_1, B_1;
  logic [3:0]  Sel_Op_0, Sel_Op_1;
  logic        Resp_Valid;
  logic        Resp_Ready;
  logic        Resp_Id;
  logic [15:0] Resultado;
  logic        Maior, Menor, Igual, Erro;

  ula_arbitro_2p dut (
    .clk(clk), .rst(rst),
    .Req_Valid_0(Req_Valid_0), .Req_Valid_1(Req_Valid_1),
    .Req_Ready_0(Req_Ready_0), .Req_Ready_1(Req_Ready_1),
    .A_0(A_0), .B_0(B_0), .A_1(A_1), .B_1(B_1),
    .Sel_Op_0(Sel_Op_0), .Sel_Op_1(Sel_Op_1),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Id(Resp_Id),
    .Resultado(Resultado), .Maior(Maior), .Menor(Menor), .Igual(Igual), .Erro(Erro)
  );

  typedef struct {
    logic        id;
    logic [15:0] res;
    bit          chk_res;
    logic        maior, menor, igual, erro;
    int          hs_cyc;
    bit          seen;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   busy = 0;
  bit   prefer = 0;
  bit   rr_rand = 0;
  int   hold = 0;
  int   grants[$];

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t modelo(logic id, logic [7:0] a, logic [7:0] b, logic [3:0] op);
    exp_t e;
    int ai = int'(a);
    int bi = int'(b);
    e.id = id; e.chk_res = 1; e.erro = 0; e.res = 16'h0000;
    e.hs_cyc = 0; e.seen = 0;
    case (op)
      4'd0:  e.res = 16'((ai + bi) % 256);
      4'd1:  e.res = 16'((ai - bi + 256) % 256);
      4'd2:  e.res = 16'(ai * bi);
      4'd3, 4'd4: begin
        if (bi == 0) begin
`ifdef ULA_ARB_CHECA_DIV0_EN
          e.res = 16'hFFFF; e.erro = 1;
`else
          e.chk_res = 0;
`endif
        end else begin
          e.res = (op == 4'd3) ? 16'(ai / bi) : 16'(ai % bi);
        end
      end
      4'd6:  e.res = {8'h00, a & b};
      4'd7:  e.res = {8'h00, a | b};
      4'd8:  e.res = 16'(255 - (ai & bi));
      4'd9:  e.res = 16'(255 - (ai | bi));
      4'd10: e.res = {8'h00, a ^ b};
      4'd11: e.res = 16'(255 - ai);
      default: begin e.res = 16'h0000; e.erro = 1; end
    endcase
    e.maior = ai > bi;
    e.menor = ai < bi;
    e.igual = ai == bi;
    return e;
  endfunction

  // One clock: check arbitration against the model, record handshakes, then update drivers.
  task automatic tick();
    bit hs0 = 0, hs1 = 0, er0 = 0, er1 = 0;
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (!(busy || Resp_Valid)) begin
        if (Req_Valid_0 && Req_Valid_1) begin
          er0 = (prefer == 0); er1 = (prefer == 1);
        end else begin
          er0 = Req_Valid_0; er1 = Req_Valid_1;
        end
      end
      chk("req_ready_0", Req_Ready_0, er0);
      chk("req_ready_1", Req_Ready_1, er1);
      hs0 = Req_Valid_0 && Req_Ready_0;
      hs1 = Req_Valid_1 && Req_Ready_1;
      if (Resp_Valid && Resp_Ready) busy = 0;
      if (hs0 || hs1) begin
        e = hs1 ? modelo(1'b1, A_1, B_1, Sel_Op_1) : modelo(1'b0, A_0, B_0, Sel_Op_0);
        e.hs_cyc = cyc;
        exp_q.push_back(e);
        grants.push_back(hs1 ? 1 : 0);
        busy = 1;
        prefer = hs1 ? 1'b0 : 1'b1;
      end
    end
    @(posedge clk); #1;
    if (hs0) begin Req_Valid_0 = 0; A_0 = 8'($urandom); B_0 = 8'($urandom); Sel_Op_0 = 4'($urandom); end
    if (hs1) begin Req_Valid_1 = 0; A_1 = 8'($urandom); B_1 = 8'($urandom); Sel_Op_1 = 4'($urandom); end
    if (hold > 0) begin Resp_Ready = 0; hold--; end
    else Resp_Ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic set_req(int p, logic [7:0] a, logic [7:0] b, logic [3:0] op);
    if (p == 0) begin A_0 = a; B_0 = b; Sel_Op_0 = op; Req_Valid_0 = 1; end
    else        begin A_1 = a; B_1 = b; Sel_Op_1 = op; Req_Valid_1 = 1; end
  endtask

  task automatic wait_accept();
    int n = 0;
    while ((Req_Valid_0 || Req_Valid_1) && n < 60) begin tick(); n++; end
    if (n >= 60) chk("accept_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin tick(); n++; end
    if (n >= 60) chk("drain_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_resp_valid"}, Resp_Valid, 0);
    chk({tag, "_resp_id"}, Resp_Id, 0);
    chk({tag, "_resultado"}, Resultado, 0);
    chk({tag, "_flags"}, {Maior, Menor, Igual}, 0);
    chk({tag, "_erro"}, Erro, 0);
    chk({tag, "_req_ready"}, {Req_Ready_0, Req_Ready_1}, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    exp_q.delete();
    busy = 0;
    prefer = 0;
  endtask

  // Monitor: compares every cycle a response is presented, pops on acceptance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && Resp_Valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = exp_q[0];
          chk("resp_id", Resp_Id, e.id);
          if (e.chk_res) chk("resultado", Resultado, e.res);
          chk("flags", {Maior, Menor, Igual}, {e.maior, e.menor, e.igual});
          chk("erro", Erro, e.erro);
          if (!e.seen) begin
            chk("latency", cyc - e.hs_cyc, 2);
            exp_q[0].seen = 1;
          end
          if (Resp_Ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int first;
    rst = 1; Resp_Ready = 1;
    Req_Valid_0 = 0; Req_Valid_1 = 0;
    A_0 = 0; B_0 = 0; A_1 = 0; B_1 = 0; Sel_Op_0 = 0; Sel_Op_1 = 0;
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 8'd1, 8'd1, 4'd0);
    #1;
    check_reset_outputs("reset");
    Req_Valid_0 = 0;
    @(posedge clk); #1; rst = 0;

    // Port 0 alone: 50 + 30
    set_req(0, 8'd50, 8'd30, 4'b0000);
    wait_accept(); drain();

    // Contention from a fresh reset: 20*20 on port 0, 100/5 on port 1
    do_reset(); @(posedge clk); #1; rst = 0;
    grants.delete();
    set_req(0, 8'd20, 8'd20, 4'b0010);
    set_req(1, 8'd100, 8'd5, 4'b0011);
    wait_accept(); drain();
    first = (grants.size() > 0) ? grants[0] : 2;
    chk("first_grant_after_reset", first, 0);
    for (int r = 0; r < 2; r++) begin
      set_req(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 4)));
      set_req(1, 8'($urandom), 8'($urandom), 4'($urandom_range(6, 11)));
      wait_accept(); drain();
    end

    // Backpressure: 23 mod 5 held while Resp_Ready is low
    set_req(1, 8'd23, 8'd5, 4'b0100);
    hold = 7;
    wait_accept(); drain();

    // Illegal opcode, equal operands
    set_req(0, 8'd42, 8'd42, 4'b1100);
    wait_accept(); drain();

    // Division by zero
    set_req(0, 8'd7, 8'd0, 4'b0011);
    wait_accept(); drain();

    // Random traffic with random response backpressure
    rr_rand = 1;
    for (int i = 0; i < 500; i++) begin
      if (!Req_Valid_0 && $urandom_range(0, 1) == 1)
        set_req(0, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), 4'($urandom));
      if (!Req_Valid_1 && $urandom_range(0, 1) == 1)
        set_req(1, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), 4'($urandom));
      tick();
    end
    Req_Valid_0 = 0; Req_Valid_1 = 0; rr_rand = 0;
    drain();

    // Reset while an operation is executing
    set_req(1, 8'd200, 8'd1, 4'b0000);
    wait_accept(); drain();
    grants.delete();
    set_req(1, 8'd9, 8'd3, 4'b0010);
    wait_accept();
    do_reset();
    check_reset_outputs("reset_mid_op");
    @(posedge clk); #1; rst = 0;
    grants.delete();
    set_req(0, 8'd3, 8'd4, 4'b0111);
    set_req(1, 8'd5, 8'd6, 4'b1010);
    wait_accept(); drain();
    first = (grants.size() > 0) ? grants[0] : 2;
    chk("grant_after_mid_reset", first, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
